// File: rtl/imem_pkg.sv
// Shared types and default parameters for the instruction-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    // Which requester owns the read data returning from memory this cycle
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DBG   = 2'd2
    } owner_e;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int WORD_AW          = DEF_ADDR_W - 2;

endpackage

// File: rtl/imem_sram.sv
// Behavioural single-port word memory, synchronous read, write-first.
// Latency: read data valid one cycle after en with we=0.
// Backpressure: none; accepts one access every cycle.
module imem_sram #(
    parameter int WIDTH   = 32,
    parameter int WORD_AW = 14
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [WORD_AW-1:0] addr,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata
);

    localparam int DEPTH = 1 << WORD_AW;

    logic [WIDTH-1:0] mem [DEPTH];

    // Write-first port: a write also presents the new word on rdata next cycle
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates one instruction memory between fetch (F, priority) and debug/loader (D).
// Latency: grant is combinational; read data returns one cycle after the grant.
// Backpressure: losing requester holds its request until gnt; D is guaranteed a grant after STARVE_LIMIT F wins.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              f_req,
    input  logic [WIDTH-1:0]  f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [WIDTH-1:0]  f_rdata,
    // debug / loader port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WIDTH-1:0]  d_addr,
    input  logic [WIDTH-1:0]  d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WIDTH-1:0]  d_rdata,
    // memory macro
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_e     owner_q, owner_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       d_prio_q, d_prio_d;

    // Byte-offset bits and bits above the decoded range are intentionally dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[WIDTH-1:ADDR_W], f_addr[1:0],
                                d_addr[WIDTH-1:ADDR_W], d_addr[1:0]};

    // Fixed fetch priority, overridden by d_prio once D has waited long enough
    always_comb begin
        f_gnt = f_req & ~(d_req & d_prio_q);
        d_gnt = d_req & ~f_gnt;
    end

    // Steer the winner onto the memory port; idle and fetch cycles carry zero write data
    always_comb begin
        mem_en    = f_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = d_gnt ? d_addr[ADDR_W-1:2] : f_addr[ADDR_W-1:2];
        mem_wdata = d_gnt ? d_wdata : '0;
    end

    // Count F wins while D waits; raise d_prio for the cycle after the limit is hit
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        d_prio_d     = d_prio_q;
        if (d_gnt || !d_req) begin
            starve_cnt_d = 4'd0;
        end else if (f_gnt && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        if (d_gnt) begin
            d_prio_d = 1'b0;
        end else if (starve_cnt_d >= LIMIT) begin
            d_prio_d = 1'b1;
        end
    end

    // Response owner: who gets mem_rdata next cycle (writes and flushed fetches get none)
    always_comb begin
        owner_d = NONE;
        if (f_gnt && !f_flush) begin
            owner_d = FETCH;
        end else if (d_gnt && !d_we) begin
            owner_d = DBG;
        end
    end

    // Response outputs gated by the owner so the non-owning port always sees zero
    always_comb begin
        f_rvalid = (owner_q == FETCH);
        d_rvalid = (owner_q == DBG);
        f_rdata  = f_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

    // State registers; reset drops any in-flight response immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= NONE;
            starve_cnt_q <= 4'd0;
            d_prio_q     <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            d_prio_q     <= d_prio_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a write-first behavioural memory behind it.
// Inputs are driven at the falling edge; all outputs are sampled 1 time unit later.
// Latency: registered responses appear at the falling edge after their grant.
module tb_imem_arbiter;
    import imem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        f_req, f_flush, f_gnt, f_rvalid;
    logic [31:0] f_addr, f_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    imem_arbiter #(.WIDTH(32), .ADDR_W(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_sram #(.WIDTH(32), .WORD_AW(14)) u_mem (
        .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
        .wdata(mem_wdata), .rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        f_req = 0; f_addr = '0; f_flush = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    endtask

    // Loader write through the D port (preload only)
    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        idle_inputs();
        d_req = 1; d_we = 1; d_addr = addr; d_wdata = data;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        n_tests++;
        if ({f_rvalid, d_rvalid, f_gnt, d_gnt, mem_en, mem_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {f_rvalid, d_rvalid, f_gnt, d_gnt, mem_en, mem_we});
        end
        n_tests++;
        if ({f_rdata, d_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got f=%h d=%h required 0", f_rdata, d_rdata);
        end
        n_tests++;
        if ({dut.starve_cnt_q, dut.d_prio_q} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_counters: got cnt=%0d prio=%b required 0/0",
                     dut.starve_cnt_q, dut.d_prio_q);
        end
    endtask

    task automatic test_fetch_stream();
        logic [31:0] words [3];
        words[0] = 32'h00500093; words[1] = 32'h00A00113; words[2] = 32'h002081B3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                f_req = 1; f_addr = 32'(i * 4);
            end else begin
                idle_inputs();
            end
            #1;
            if (i < 3) begin
                n_tests++;
                if ({f_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
                    {4'b1010, 14'(i), 32'h0}) begin
                    n_fail++;
                    $display("FAIL fetch_grant[%0d]: got gnt=%b en=%b addr=%h wd=%h required gnt=1 en=1 addr=%h wd=0",
                             i, f_gnt, mem_en, mem_addr, mem_wdata, i);
                end
            end
            if (i > 0) begin
                n_tests++;
                if ({f_rvalid, f_rdata} !== {1'b1, words[i-1]}) begin
                    n_fail++;
                    $display("FAIL fetch_data[%0d]: got v=%b d=%h required v=1 d=%h",
                             i - 1, f_rvalid, f_rdata, words[i-1]);
                end
            end
        end
    endtask

    task automatic test_align_wrap();
        @(negedge clk);
        f_req = 1; f_addr = 32'h0001_0006;
        #1;
        n_tests++;
        if ({f_gnt, mem_addr} !== {1'b1, 14'h0001}) begin
            n_fail++;
            $display("FAIL align_addr: got gnt=%b mem_addr=%h required 1/0001", f_gnt, mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if ({f_rvalid, f_rdata} !== {1'b1, 32'h00A00113}) begin
            n_fail++;
            $display("FAIL align_data: got v=%b d=%h required v=1 d=00a00113", f_rvalid, f_rdata);
        end
    endtask

    task automatic test_starvation();
        // expected {f_gnt, d_gnt} for cycles 1..6 with both requesting
        logic [1:0] exp_gnt [6];
        exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            f_req = 1; f_addr = 32'h0;
            d_req = 1; d_we = 0; d_addr = 32'h8;
            #1;
            n_tests++;
            if ({f_gnt, d_gnt} !== exp_gnt[c]) begin
                n_fail++;
                $display("FAIL starve_gnt[cycle %0d]: got f/d=%b required %b",
                         c + 1, {f_gnt, d_gnt}, exp_gnt[c]);
            end
            if (c == 5) begin
                n_tests++;
                if ({f_rvalid, d_rvalid, d_rdata} !== {2'b01, 32'h002081B3}) begin
                    n_fail++;
                    $display("FAIL starve_dread: got fv=%b dv=%b d=%h required fv=0 dv=1 d=002081b3",
                             f_rvalid, d_rvalid, d_rdata);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_flush();
        // A: plain fetch word0; B: flushed fetch at 0x10; C: fetch 0x14; D: idle
        @(negedge clk);
        f_req = 1; f_addr = 32'h0;
        @(negedge clk);
        f_addr = 32'h10; f_flush = 1;
        #1;
        n_tests++;
        if ({f_gnt, f_rvalid, f_rdata} !== {2'b11, 32'h00500093}) begin
            n_fail++;
            $display("FAIL flush_keep_prev: got gnt=%b v=%b d=%h required 1/1/00500093",
                     f_gnt, f_rvalid, f_rdata);
        end
        @(negedge clk);
        f_addr = 32'h14; f_flush = 0;
        #1;
        n_tests++;
        if ({f_rvalid, f_rdata} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_suppress: got v=%b d=%h required v=0 d=0", f_rvalid, f_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if ({f_rvalid, f_rdata} !== {1'b1, 32'h22222222}) begin
            n_fail++;
            $display("FAIL flush_resume: got v=%b d=%h required v=1 d=22222222", f_rvalid, f_rdata);
        end
    endtask

    task automatic test_loader_rw();
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        #1;
        n_tests++;
        if ({d_gnt, f_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
            {4'b1011, 14'h0008, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL dwrite_drive: got gnt=%b en=%b we=%b addr=%h wd=%h required 1/1/1/0008/deadbeef",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        d_we = 0; d_wdata = '0;
        #1;
        n_tests++;
        if ({d_gnt, mem_we, d_rvalid} !== 3'b100) begin
            n_fail++;
            $display("FAIL dwrite_no_rvalid: got gnt=%b we=%b rvalid=%b required 1/0/0",
                     d_gnt, mem_we, d_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if ({d_rvalid, d_rdata, f_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL dread_back: got v=%b d=%h fv=%b required v=1 d=deadbeef fv=0",
                     d_rvalid, d_rdata, f_rvalid);
        end
        n_tests++;
        if ({mem_en, mem_wdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL idle_mem: got en=%b wd=%h required 0/0", mem_en, mem_wdata);
        end
    endtask

    task automatic test_reset_midstream();
        // four F wins with D waiting: d_prio armed, fetch outstanding
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            f_req = 1; f_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h0;
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({f_rvalid, dut.d_prio_q} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_state: got rvalid=%b prio=%b required 1/1", f_rvalid, dut.d_prio_q);
        end
        rst_n = 0;
        #1;
        n_tests++;
        if ({f_rvalid, f_rdata, dut.starve_cnt_q, dut.d_prio_q} !== 38'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got rvalid=%b d=%h cnt=%0d prio=%b required all 0",
                     f_rvalid, f_rdata, dut.starve_cnt_q, dut.d_prio_q);
        end
        n_tests++;
        if (dut.owner_q !== NONE) begin
            n_fail++;
            $display("FAIL midreset_owner: got %0d required NONE", dut.owner_q);
        end
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        f_req = 1; f_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h0;
        #1;
        n_tests++;
        if ({f_gnt, d_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_gnt: got f/d=%b required 10", {f_gnt, d_gnt});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if ({f_rvalid, f_rdata} !== {1'b1, 32'h002081B3}) begin
            n_fail++;
            $display("FAIL post_reset_fetch: got v=%b d=%h required v=1 d=002081b3", f_rvalid, f_rdata);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        load_word(32'h00, 32'h00500093);
        load_word(32'h04, 32'h00A00113);
        load_word(32'h08, 32'h002081B3);
        load_word(32'h10, 32'h11111111);
        load_word(32'h14, 32'h22222222);
        test_fetch_stream();
        test_align_wrap();
        test_starvation();
        test_flush();
        test_loader_rw();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
